// File: rtl/sarray_mem_resp_pkg.sv
// Shared constants and address helpers for the sarray memory responder.
// Load/store widths here must track the sarray front-end port widths.
package sarray_mem_resp_pkg;

  localparam int unsigned SARRAY_LOAD_WIDTH  = 256;
  localparam int unsigned SARRAY_STORE_WIDTH = 256;
  localparam int unsigned SARRAY_RQ_DEPTH    = 4;

  // Byte-offset bits below the word index.
  function automatic int unsigned addr_off_bits(input int unsigned load_width);
    return $clog2(load_width / 8);
  endfunction

  // Word-index bits for a scratchpad of the given depth.
  function automatic int unsigned addr_idx_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Credit counter must hold 0..rq_depth inclusive.
  function automatic int unsigned credit_bits(input int unsigned rq_depth);
    return $clog2(rq_depth + 1);
  endfunction

  localparam int unsigned SARRAY_CREDIT_WIDTH = $clog2(SARRAY_RQ_DEPTH + 1);

endpackage

// File: rtl/sarray_mem_resp_if.sv
// AR/R/AW bus between the sarray load/store initiator and the memory responder.
interface sarray_mem_resp_if
  import sarray_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LOAD_WIDTH  = SARRAY_LOAD_WIDTH,
  parameter int unsigned STORE_WIDTH = SARRAY_STORE_WIDTH
);
  logic                   ar_valid_i;
  logic                   ar_ready_o;
  logic [ADDR_WIDTH-1:0]  ar_addr_i;
  logic                   r_valid_o;
  logic                   r_ready_i;
  logic [LOAD_WIDTH-1:0]  r_data_o;
  logic                   aw_valid_i;
  logic                   aw_ready_o;
  logic [ADDR_WIDTH-1:0]  aw_addr_i;
  logic [STORE_WIDTH-1:0] aw_data_i;
  logic                   misalign_o;
  logic                   busy_o;

  modport master (
    output ar_valid_i, ar_addr_i, r_ready_i, aw_valid_i, aw_addr_i, aw_data_i,
    input  ar_ready_o, r_valid_o, r_data_o, aw_ready_o, misalign_o, busy_o
  );

  modport slave (
    input  ar_valid_i, ar_addr_i, r_ready_i, aw_valid_i, aw_addr_i, aw_data_i,
    output ar_ready_o, r_valid_o, r_data_o, aw_ready_o, misalign_o, busy_o
  );
endinterface

// File: rtl/sarray_resp_fifo.sv
// Synchronous response FIFO; extra pointer wrap bit distinguishes full from empty.
module sarray_resp_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  // Storage is not reset; pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[IDX_W-1:0]] <= push_data;
  end

  assign head_data = mem_q[rd_q[IDX_W-1:0]];
  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);

endmodule

// File: rtl/sarray_mem_resp.sv
// Memory-side responder: word scratchpad with AW stores and credit-controlled,
// fixed-latency AR reads returned in order through a response FIFO.
module sarray_mem_resp
  import sarray_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LOAD_WIDTH  = SARRAY_LOAD_WIDTH,
  parameter int unsigned STORE_WIDTH = SARRAY_STORE_WIDTH,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned RQ_DEPTH    = SARRAY_RQ_DEPTH
) (
  input logic             clk,
  input logic             rst_n,
  sarray_mem_resp_if.slave bus
);
  localparam int unsigned OFF = addr_off_bits(LOAD_WIDTH);
  localparam int unsigned IW  = addr_idx_bits(DEPTH);
  localparam int unsigned CW  = credit_bits(RQ_DEPTH);

  logic [CW-1:0]         credits_q;
  logic                  misalign_q;
  logic                  ar_ready_c;
  logic                  ar_hs;
  logic                  pop;
  logic                  push;
  logic [LOAD_WIDTH-1:0] push_data;
  logic [LOAD_WIDTH-1:0] rd_word;
  logic [LOAD_WIDTH-1:0] head_data;
  logic                  fifo_empty;
  logic                  unused_fifo_full;
  logic [IW-1:0]         ar_idx;
  logic [IW-1:0]         aw_idx;
  logic                  ar_off_nz;
  logic                  aw_off_nz;
  logic                  unused_addr_bits;

  logic [LOAD_WIDTH-1:0] mem_q [DEPTH];

  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign ar_idx    = bus.ar_addr_i[OFF +: IW];
  assign aw_idx    = bus.aw_addr_i[OFF +: IW];
  assign ar_off_nz = (bus.ar_addr_i[OFF-1:0] != '0);
  assign aw_off_nz = (bus.aw_addr_i[OFF-1:0] != '0);
  assign unused_addr_bits = ^{bus.ar_addr_i[ADDR_WIDTH-1:OFF+IW],
                              bus.aw_addr_i[ADDR_WIDTH-1:OFF+IW]};

  // Single-port SRAM: a store owns the cycle, reads need a free credit.
  assign ar_ready_c = (credits_q != '0) && !bus.aw_valid_i;
  assign ar_hs      = bus.ar_valid_i && ar_ready_c;
  assign pop        = !fifo_empty && bus.r_ready_i;

  always_ff @(posedge clk) begin
    if (bus.aw_valid_i) mem_q[aw_idx] <= LOAD_WIDTH'(bus.aw_data_i);
  end

  assign rd_word = mem_q[ar_idx];

  // Valid-tagged latency pipeline; never stalls because credits reserve FIFO space.
  if (RD_LAT == 1) begin : g_no_pipe
    assign push      = ar_hs;
    assign push_data = rd_word;
  end else begin : g_pipe
    localparam int unsigned NS = RD_LAT - 1;
    logic [NS-1:0]         pv_q;
    logic [LOAD_WIDTH-1:0] pd_q [NS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= ar_hs;
        for (int unsigned i = 1; i < NS; i++) pv_q[i] <= pv_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (ar_hs) pd_q[0] <= rd_word;
      for (int unsigned i = 1; i < NS; i++) pd_q[i] <= pd_q[i-1];
    end

    assign push      = pv_q[NS-1];
    assign push_data = pd_q[NS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CW'(RQ_DEPTH);
    end else if (ar_hs != pop) begin
      credits_q <= ar_hs ? (credits_q - CW'(1)) : (credits_q + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if ((ar_hs && ar_off_nz) || (bus.aw_valid_i && aw_off_nz)) begin
      misalign_q <= 1'b1;
    end
  end

  sarray_resp_fifo #(
    .WIDTH (LOAD_WIDTH),
    .DEPTH (RQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (unused_fifo_full)
  );

  assign bus.ar_ready_o = ar_ready_c;
  assign bus.aw_ready_o = 1'b1;
  assign bus.r_valid_o  = !fifo_empty;
  assign bus.r_data_o   = head_data;
  assign bus.misalign_o = misalign_q;
  assign bus.busy_o     = (credits_q != CW'(RQ_DEPTH));

endmodule

// File: tb/tb_sarray_mem_resp.sv
// Scoreboard bench for sarray_mem_resp: expected words are queued at each AR
// handshake from a flat array model and popped by an independent R monitor.
module tb_sarray_mem_resp;
  import sarray_mem_resp_pkg::*;

  localparam int unsigned AW     = 64;
  localparam int unsigned LW     = 256;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned RQ     = 4;
  localparam int unsigned BYTES  = LW / 8;

  typedef logic [LW-1:0] word_t;
  typedef logic [AW-1:0] addr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  word_t model_mem [DEPTH];
  bit    model_mis = 1'b0;
  word_t exp_q [$];
  addr_t ar_q [$];
  int    last_ar_cyc = -1;
  int    n_ar_acc = 0;

  sarray_mem_resp_if #(.ADDR_WIDTH(AW), .LOAD_WIDTH(LW), .STORE_WIDTH(LW)) bus ();

  sarray_mem_resp #(
    .ADDR_WIDTH (AW), .LOAD_WIDTH (LW), .STORE_WIDTH (LW),
    .DEPTH (DEPTH), .RD_LAT (RD_LAT), .RQ_DEPTH (RQ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input addr_t a);
    return int'((a / 64'(BYTES)) % 64'(DEPTH));
  endfunction

  function automatic bit misaligned(input addr_t a);
    return (a % 64'(BYTES)) != 64'd0;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < LW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // AR driver: presents the head of ar_q, logs the expected word on handshake.
  initial begin : ar_drv
    bus.ar_valid_i = 1'b0;
    bus.ar_addr_i  = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.ar_valid_i = rst_n && (ar_q.size() > 0);
      bus.ar_addr_i  = (ar_q.size() > 0) ? ar_q[0] : '0;
      #1;
      if (rst_n && bus.ar_valid_i && bus.ar_ready_o) begin
        exp_q.push_back(model_mem[widx(ar_q[0])]);
        if (misaligned(ar_q[0])) model_mis = 1'b1;
        void'(ar_q.pop_front());
        last_ar_cyc = cyc;
        n_ar_acc++;
      end
    end
  end

  // R monitor: compares each accepted beat and checks data hold under backpressure.
  initial begin : r_mon
    bit    hold;
    word_t hold_d;
    hold = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold && bus.r_valid_o) chk("r_data_hold", bus.r_data_o, hold_d);
        hold   = bus.r_valid_o && !bus.r_ready_i;
        hold_d = bus.r_data_o;
        if (bus.r_valid_o && bus.r_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL r_beat_unexpected got=%0h exp=none", bus.r_data_o);
          end else begin
            chk("r_data", bus.r_data_o, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic aw_write(input addr_t a, input word_t d);
    @(negedge clk);
    bus.aw_valid_i = 1'b1;
    bus.aw_addr_i  = a;
    bus.aw_data_i  = d;
    model_mem[widx(a)] = d;
    if (misaligned(a)) model_mis = 1'b1;
  endtask

  task automatic aw_off();
    @(negedge clk);
    bus.aw_valid_i = 1'b0;
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n_ar_acc < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chki({name, "_accept"}, n_ar_acc, target);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((ar_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chki({name, "_drain_pending"}, ar_q.size() + exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin : main
    word_t d;
    addr_t a;
    int    n0;
    int    free_cyc;

    bus.r_ready_i  = 1'b0;
    bus.aw_valid_i = 1'b0;
    bus.aw_addr_i  = '0;
    bus.aw_data_i  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rst_r_valid", bus.r_valid_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk1("rst_misalign", bus.misalign_o, 1'b0);
    chk1("rst_ar_ready", bus.ar_ready_o, 1'b1);
    chk1("rst_aw_ready", bus.aw_ready_o, 1'b1);

    // Give every scratchpad word a known value.
    for (int i = 0; i < int'(DEPTH); i++) aw_write(addr_t'(i * BYTES), rand_word());
    aw_write(addr_t'(0), {32{8'hA5}});
    aw_off();

    // Basic read and exact first-beat latency.
    bus.r_ready_i = 1'b1;
    n0 = n_ar_acc;
    ar_q.push_back(addr_t'(0));
    wait_acc("basic", n0 + 1, 20);
    while (cyc < last_ar_cyc + int'(RD_LAT) - 1) @(negedge clk);
    #3;
    chk1("basic_r_valid_early", bus.r_valid_o, 1'b0);
    @(negedge clk);
    #3;
    chki("basic_latency_cycle", cyc - last_ar_cyc, int'(RD_LAT));
    chk1("basic_r_valid", bus.r_valid_o, 1'b1);
    chk("basic_r_data", bus.r_data_o, {32{8'hA5}});
    drain("basic", 50);
    chk1("basic_busy_idle", bus.busy_o, 1'b0);

    // Backpressure: only RQ reads fit while R is stalled.
    @(negedge clk);
    bus.r_ready_i = 1'b0;
    n0 = n_ar_acc;
    for (int i = 0; i < 6; i++) ar_q.push_back(addr_t'(i * 'h100));
    repeat (12) @(negedge clk);
    #2;
    chki("bp_accepted", n_ar_acc - n0, int'(RQ));
    chk1("bp_ar_ready_low", bus.ar_ready_o, 1'b0);
    chk1("bp_busy", bus.busy_o, 1'b1);
    chk1("bp_r_valid", bus.r_valid_o, 1'b1);
    @(negedge clk);
    bus.r_ready_i = 1'b1;
    drain("bp", 100);
    chki("bp_total_accepted", n_ar_acc - n0, 6);

    // Arbitration: stores block reads; AR goes in the first store-free cycle.
    @(negedge clk);
    n0 = n_ar_acc;
    ar_q.push_back(addr_t'(11 * BYTES));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      d = rand_word();
      a = addr_t'((10 + k) * BYTES);
      bus.aw_valid_i = 1'b1;
      bus.aw_addr_i  = a;
      bus.aw_data_i  = d;
      model_mem[widx(a)] = d;
      #2;
      chk1("arb_ar_ready_low", bus.ar_ready_o, 1'b0);
    end
    @(negedge clk);
    bus.aw_valid_i = 1'b0;
    free_cyc = cyc;
    wait_acc("arb", n0 + 1, 20);
    chki("arb_accept_cycle", last_ar_cyc, free_cyc);
    ar_q.push_back(addr_t'(10 * BYTES));
    ar_q.push_back(addr_t'(12 * BYTES));
    drain("arb", 100);

    // Wrap-around: word DEPTH+3 aliases word 3.
    aw_write(addr_t'((DEPTH + 3) * BYTES), rand_word());
    aw_off();
    ar_q.push_back(addr_t'(3 * BYTES));
    drain("wrap", 50);
    chk1("wrap_misalign_clear", bus.misalign_o, 1'b0);

    // Misaligned read returns word 8 and sets the sticky flag until reset.
    ar_q.push_back(addr_t'('h104));
    drain("mis", 50);
    chk1("mis_set", bus.misalign_o, 1'b1);
    aw_write(addr_t'(2 * BYTES), rand_word());
    aw_off();
    ar_q.push_back(addr_t'(2 * BYTES));
    drain("mis_sticky", 50);
    chk1("mis_sticky", bus.misalign_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    model_mis = 1'b0;
    #1;
    chk1("mis_reset_clear", bus.misalign_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random mix of stores, reads and R backpressure.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.r_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        a = {$urandom, $urandom};
        if ($urandom_range(0, 7) != 0) a[4:0] = '0;
        d = rand_word();
        bus.aw_valid_i = 1'b1;
        bus.aw_addr_i  = a;
        bus.aw_data_i  = d;
        model_mem[widx(a)] = d;
        if (misaligned(a)) model_mis = 1'b1;
      end else begin
        bus.aw_valid_i = 1'b0;
      end
      if (ar_q.size() < 3 && $urandom_range(0, 1) == 1) begin
        a = {$urandom, $urandom};
        if ($urandom_range(0, 7) != 0) a[4:0] = '0;
        ar_q.push_back(a);
      end
    end
    @(negedge clk);
    bus.aw_valid_i = 1'b0;
    bus.r_ready_i  = 1'b1;
    drain("rand", 500);
    chk1("rand_misalign", bus.misalign_o, model_mis);
    chk1("rand_busy_idle", bus.busy_o, 1'b0);

    // Reset with reads in flight: nothing may come back afterwards.
    bus.r_ready_i = 1'b0;
    n0 = n_ar_acc;
    for (int i = 0; i < 3; i++) ar_q.push_back(addr_t'((20 + i) * BYTES));
    wait_acc("rst_mid", n0 + 3, 20);
    rst_n = 1'b0;
    exp_q.delete();
    ar_q.delete();
    model_mis = 1'b0;
    #1;
    chk1("rst_mid_r_valid", bus.r_valid_o, 1'b0);
    chk1("rst_mid_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.r_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #3;
      chk1("rst_mid_no_stale", bus.r_valid_o, 1'b0);
    end
    // Full credit pool restored: exactly RQ reads accepted while R is stalled.
    @(negedge clk);
    bus.r_ready_i = 1'b0;
    n0 = n_ar_acc;
    for (int i = 0; i < 5; i++) ar_q.push_back(addr_t'((30 + i) * BYTES));
    repeat (12) @(negedge clk);
    chki("rst_mid_credits", n_ar_acc - n0, int'(RQ));
    bus.r_ready_i = 1'b1;
    drain("rst_mid", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
